// File: rtl/odd_siralayici_pkg.sv
// Shared definitions for the trap sequencer: FSM encoding, interrupt codes,
// MSTATUS/MIE bit positions and the machine-mode CSR addresses it writes.
package odd_siralayici_pkg;

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        BEKLE     = 3'd1,
        Y_MEPC    = 3'd2,
        Y_MCAUSE  = 3'd3,
        Y_MTVAL   = 3'd4,
        Y_MSTATUS = 3'd5,
        YONLENDIR = 3'd6
    } odd_durum_e;

    // Interrupt cause codes
    localparam int unsigned KESME_KOD_MEI = 11;
    localparam int unsigned KESME_KOD_MTI = 7;

    // Reserved exception code that marks an MRET report
    localparam int unsigned EXC_CODE_MRET = 31;

    // MSTATUS / MIE bit indices
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_BIT  = 11;
    localparam int unsigned MIE_MTIE_BIT     = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;

    localparam logic [1:0] PRIV_MACHINE = 2'b11;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

endpackage

// File: rtl/odd_siralayici.sv
// Trap sequencer in front of the CSR unit.
// Selects one exception / MRET / interrupt, writes MEPC, MCAUSE, MTVAL and
// MSTATUS through a ready/valid CSR write port, then redirects fetch with a
// one-cycle flush. The pipeline is stalled from detection up to the redirect.
// Ports: clk_i/rstn_i (async active-low); coz/yurut/bellek trap reports;
// yurut_odd_bilgi_i (MTVAL); emekli_ps_i/emekli_gecerli_i (interrupt MEPC);
// meip_i/mtip_i; current mstatus/mie/mtvec/mepc and their valid flags;
// csr_yaz_* write port; duraklat_o (combinational stall), bosalt_o,
// getir_ps_o/getir_ps_gecerli_o redirect.
// Build option: ODD_VEKTORLU_EN enables vectored interrupt redirect when
// mtvec_i[1:0]==1 (base + 4*code); otherwise every trap goes to the base.
module odd_siralayici
    import odd_siralayici_pkg::*;
#(
    parameter int unsigned MXLEN         = 32,
    parameter int unsigned PS_BIT        = 32,
    parameter int unsigned EXC_CODE_BIT  = 5,
    parameter int unsigned CSR_ADRES_BIT = 12
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [PS_BIT-1:0]        coz_odd_ps_i,
    input  logic [EXC_CODE_BIT-1:0]  coz_odd_kod_i,
    input  logic                     coz_odd_gecerli_i,
    input  logic [PS_BIT-1:0]        yurut_odd_ps_i,
    input  logic [EXC_CODE_BIT-1:0]  yurut_odd_kod_i,
    input  logic                     yurut_odd_gecerli_i,
    input  logic [MXLEN-1:0]         yurut_odd_bilgi_i,
    input  logic [PS_BIT-1:0]        bellek_odd_ps_i,
    input  logic [EXC_CODE_BIT-1:0]  bellek_odd_kod_i,
    input  logic                     bellek_odd_gecerli_i,
    input  logic [PS_BIT-1:0]        emekli_ps_i,
    input  logic                     emekli_gecerli_i,
    input  logic                     meip_i,
    input  logic                     mtip_i,
    input  logic [MXLEN-1:0]         mstatus_i,
    input  logic [MXLEN-1:0]         mie_i,
    input  logic [MXLEN-1:0]         mtvec_i,
    input  logic [MXLEN-1:0]         mepc_i,
    input  logic                     mtvec_gecerli_i,
    input  logic                     mepc_gecerli_i,
    output logic [CSR_ADRES_BIT-1:0] csr_yaz_adres_o,
    output logic [MXLEN-1:0]         csr_yaz_veri_o,
    output logic                     csr_yaz_gecerli_o,
    input  logic                     csr_yaz_hazir_i,
    output logic                     duraklat_o,
    output logic                     bosalt_o,
    output logic [PS_BIT-1:0]        getir_ps_o,
    output logic                     getir_ps_gecerli_o
);

    odd_durum_e durum_q, durum_d;

    logic [PS_BIT-1:0]        ps_q, ps_d, hedef_q, hedef_d, sec_ps, tvec_hedef, getir_ps_d;
    logic [EXC_CODE_BIT-1:0]  kod_q, kod_d, sec_kod;
    logic [MXLEN-1:0]         tval_q, tval_d, mcause, mstatus_yeni, veri_d;
    logic [CSR_ADRES_BIT-1:0] adres_d;
    logic kesme_q, kesme_d, mret_q, mret_d;
    logic sec_gecerli, sec_kesme, sec_mret, sec_yurut, mei_istek, mti_istek;
    logic yaz_gecerli_d, bosalt_d, getir_gecerli_d;
    logic unused;

    assign unused = ^{mie_i, mtvec_i[1:0]};

    assign mei_istek = mstatus_i[MSTATUS_MIE_BIT] & mie_i[MIE_MEIE_BIT] & meip_i & emekli_gecerli_i;
    assign mti_istek = mstatus_i[MSTATUS_MIE_BIT] & mie_i[MIE_MTIE_BIT] & mtip_i & emekli_gecerli_i;

    // Trap source selection: bellek > yurut > coz > MEI > MTI
    always_comb begin
        sec_gecerli = 1'b0;
        sec_kesme   = 1'b0;
        sec_yurut   = 1'b0;
        sec_ps      = '0;
        sec_kod     = '0;
        if (bellek_odd_gecerli_i) begin
            sec_gecerli = 1'b1;
            sec_ps      = bellek_odd_ps_i;
            sec_kod     = bellek_odd_kod_i;
        end else if (yurut_odd_gecerli_i) begin
            sec_gecerli = 1'b1;
            sec_yurut   = 1'b1;
            sec_ps      = yurut_odd_ps_i;
            sec_kod     = yurut_odd_kod_i;
        end else if (coz_odd_gecerli_i) begin
            sec_gecerli = 1'b1;
            sec_ps      = coz_odd_ps_i;
            sec_kod     = coz_odd_kod_i;
        end else if (mei_istek) begin
            sec_gecerli = 1'b1;
            sec_kesme   = 1'b1;
            sec_ps      = emekli_ps_i;
            sec_kod     = EXC_CODE_BIT'(KESME_KOD_MEI);
        end else if (mti_istek) begin
            sec_gecerli = 1'b1;
            sec_kesme   = 1'b1;
            sec_ps      = emekli_ps_i;
            sec_kod     = EXC_CODE_BIT'(KESME_KOD_MTI);
        end
        sec_mret = sec_gecerli & ~sec_kesme & (sec_kod == EXC_CODE_BIT'(EXC_CODE_MRET));
    end

    // CSR write payloads derived from the captured trap
    always_comb begin
        mcause                    = '0;
        mcause[EXC_CODE_BIT-1:0]  = kod_q;
        mcause[MXLEN-1]           = kesme_q;

        mstatus_yeni = mstatus_i;
        if (mret_q) begin
            mstatus_yeni[MSTATUS_MIE_BIT]  = mstatus_i[MSTATUS_MPIE_BIT];
            mstatus_yeni[MSTATUS_MPIE_BIT] = 1'b1;
        end else begin
            mstatus_yeni[MSTATUS_MPIE_BIT]   = mstatus_i[MSTATUS_MIE_BIT];
            mstatus_yeni[MSTATUS_MIE_BIT]    = 1'b0;
            mstatus_yeni[MSTATUS_MPP_BIT +: 2] = PRIV_MACHINE;
        end

        tvec_hedef = PS_BIT'({mtvec_i[MXLEN-1:2], 2'b00});
`ifdef ODD_VEKTORLU_EN
        if (kesme_q && (mtvec_i[1:0] == 2'b01)) begin
            tvec_hedef = tvec_hedef + PS_BIT'({kod_q, 2'b00});
        end
`endif
    end

    // Next state, captured trap and registered output values
    always_comb begin
        durum_d         = durum_q;
        ps_d            = ps_q;
        kod_d           = kod_q;
        tval_d          = tval_q;
        kesme_d         = kesme_q;
        mret_d          = mret_q;
        hedef_d         = hedef_q;
        adres_d         = '0;
        veri_d          = '0;
        yaz_gecerli_d   = 1'b0;
        bosalt_d        = 1'b0;
        getir_ps_d      = '0;
        getir_gecerli_d = 1'b0;

        unique case (durum_q)
            BOSTA: begin
                if (sec_gecerli) begin
                    durum_d = BEKLE;
                    ps_d    = sec_ps;
                    kod_d   = sec_kod;
                    kesme_d = sec_kesme;
                    mret_d  = sec_mret;
                    tval_d  = sec_yurut ? yurut_odd_bilgi_i : '0;
                end
            end
            BEKLE: begin
                // Redirect target is latched once the CSR it depends on is settled
                if (mret_q ? mepc_gecerli_i : mtvec_gecerli_i) begin
                    durum_d = mret_q ? Y_MSTATUS : Y_MEPC;
                    hedef_d = mret_q ? PS_BIT'(mepc_i) : tvec_hedef;
                end
            end
            Y_MEPC:    if (csr_yaz_hazir_i) durum_d = Y_MCAUSE;
            Y_MCAUSE:  if (csr_yaz_hazir_i) durum_d = Y_MTVAL;
            Y_MTVAL:   if (csr_yaz_hazir_i) durum_d = Y_MSTATUS;
            Y_MSTATUS: if (csr_yaz_hazir_i) durum_d = YONLENDIR;
            YONLENDIR: durum_d = BOSTA;
            default:   durum_d = BOSTA;
        endcase

        // Outputs decoded from the state being entered so they register with it
        unique case (durum_d)
            Y_MEPC: begin
                yaz_gecerli_d = 1'b1;
                adres_d       = CSR_ADRES_BIT'(CSR_MEPC);
                veri_d        = MXLEN'(ps_q);
            end
            Y_MCAUSE: begin
                yaz_gecerli_d = 1'b1;
                adres_d       = CSR_ADRES_BIT'(CSR_MCAUSE);
                veri_d        = mcause;
            end
            Y_MTVAL: begin
                yaz_gecerli_d = 1'b1;
                adres_d       = CSR_ADRES_BIT'(CSR_MTVAL);
                veri_d        = tval_q;
            end
            Y_MSTATUS: begin
                yaz_gecerli_d = 1'b1;
                adres_d       = CSR_ADRES_BIT'(CSR_MSTATUS);
                // Hold the value computed on entry so data stays stable while waiting
                veri_d        = (durum_q == Y_MSTATUS) ? csr_yaz_veri_o : mstatus_yeni;
            end
            YONLENDIR: begin
                bosalt_d        = 1'b1;
                getir_gecerli_d = 1'b1;
                getir_ps_d      = hedef_q;
            end
            default: ;
        endcase
    end

    // Stall asserts in the detection cycle itself, hence combinational
    assign duraklat_o = rstn_i & (((durum_q == BOSTA) & sec_gecerli) |
                                  ((durum_q != BOSTA) & (durum_q != YONLENDIR)));

    // State, captured trap and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q            <= BOSTA;
            ps_q               <= '0;
            kod_q              <= '0;
            tval_q             <= '0;
            kesme_q            <= 1'b0;
            mret_q             <= 1'b0;
            hedef_q            <= '0;
            csr_yaz_adres_o    <= '0;
            csr_yaz_veri_o     <= '0;
            csr_yaz_gecerli_o  <= 1'b0;
            bosalt_o           <= 1'b0;
            getir_ps_o         <= '0;
            getir_ps_gecerli_o <= 1'b0;
        end else begin
            durum_q            <= durum_d;
            ps_q               <= ps_d;
            kod_q              <= kod_d;
            tval_q             <= tval_d;
            kesme_q            <= kesme_d;
            mret_q             <= mret_d;
            hedef_q            <= hedef_d;
            csr_yaz_adres_o    <= adres_d;
            csr_yaz_veri_o     <= veri_d;
            csr_yaz_gecerli_o  <= yaz_gecerli_d;
            bosalt_o           <= bosalt_d;
            getir_ps_o         <= getir_ps_d;
            getir_ps_gecerli_o <= getir_gecerli_d;
        end
    end

endmodule
